// File: rtl/tick_ctrl_pkg.sv
// Shared types and constants for the tick_ctrl run-control block.
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SHOT = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 32'd2;

    // Divisors below MIN_DIV would make the wrap compare degenerate.
    function automatic logic [31:0] clamp_div(input logic [31:0] i_div);
        logic [31:0] w_res;
        if (i_div < MIN_DIV) begin
            w_res = MIN_DIV;
        end else begin
            w_res = i_div;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/tick_ctrl_period_counter.sv
// Period counter: counts 0..div-1, issues a one-cycle tick and toggles the
// divided clock at every wrap; clear forces everything back to zero.
module tick_ctrl_period_counter #(
    parameter int CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_wrap,
    output logic             o_tick,
    output logic             o_div_clk,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_div_clk;
    logic             w_last;

    assign w_last    = (r_cnt == (i_div - CNT_W'(1)));
    // A clear wins over a coincident wrap so no tick escapes an abort.
    assign o_wrap    = i_en & ~i_clr & w_last;
    assign o_tick    = r_tick;
    assign o_div_clk = r_div_clk;
    assign o_cnt     = r_cnt;

    // Count register, tick pulse and divided clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_tick    <= 1'b0;
            r_div_clk <= 1'b0;
        end else if (i_clr) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_tick    <= 1'b0;
            r_div_clk <= 1'b0;
        end else if (o_wrap) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_tick    <= 1'b1;
            r_div_clk <= ~r_div_clk;
        end else if (i_en) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_tick    <= 1'b0;
        end else begin
            // Idle: counter parked at zero, divided clock keeps its level.
            r_cnt     <= {CNT_W{1'b0}};
            r_tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_ctrl.sv
// Run/stop/one-shot front end for a runtime-retunable clock divider:
// owns the FSM, the divisor register and the configuration handshake.
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int DEF_DIV = 500000
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iCfgValid,
    input  logic [CNT_W-1:0] iCfgDiv,
    output logic             oCfgReady,
    input  logic             iStart,
    input  logic             iOneShot,
    input  logic             iStop,
    output logic             oTick,
    output logic             oDivClk,
    output logic             oBusy,
    output logic [CNT_W-1:0] oCnt
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_cfg_div;
    logic             w_busy;
    logic             w_clr;
    logic             w_wrap;
    logic             w_load;

    assign w_busy    = (r_state != ST_IDLE);
    assign oBusy     = w_busy;
    assign oCfgReady = ~w_busy;
    assign w_clr     = w_busy & iStop;
    assign w_load    = iCfgValid & oCfgReady;
    assign w_cfg_div = CNT_W'(clamp_div(32'(iCfgDiv)));

    // State register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start outranks one-shot, stop outranks the wrap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_state_nxt = ST_RUN;
                end else if (iOneShot) begin
                    w_state_nxt = ST_SHOT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (iStop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SHOT: begin
                if (iStop || w_wrap) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHOT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Divisor register, writable only while idle.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_div <= CNT_W'(DEF_DIV);
        end else if (w_load) begin
            r_div <= w_cfg_div;
        end else begin
            r_div <= r_div;
        end
    end

    tick_ctrl_period_counter #(
        .CNT_W (CNT_W)
    ) u_period_counter (
        .i_clk     (iClk),
        .i_rst_n   (iRst),
        .i_clr     (w_clr),
        .i_en      (w_busy),
        .i_div     (r_div),
        .o_wrap    (w_wrap),
        .o_tick    (oTick),
        .o_div_clk (oDivClk),
        .o_cnt     (oCnt)
    );

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl: an elapsed-time model checked every cycle,
// plus hand-computed pins at the interesting edges.
module tb_tick_ctrl;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;

    logic             iClk;
    logic             iRst;
    logic             iCfgValid;
    logic [CNT_W-1:0] iCfgDiv;
    logic             oCfgReady;
    logic             iStart;
    logic             iOneShot;
    logic             iStop;
    logic             oTick;
    logic             oDivClk;
    logic             oBusy;
    logic [CNT_W-1:0] oCnt;

    tick_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iCfgValid (iCfgValid),
        .iCfgDiv   (iCfgDiv),
        .oCfgReady (oCfgReady),
        .iStart    (iStart),
        .iOneShot  (iOneShot),
        .iStop     (iStop),
        .oTick     (oTick),
        .oDivClk   (oDivClk),
        .oBusy     (oBusy),
        .oCnt      (oCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Model: mode 0 idle, 1 free run, 2 one-shot; t = edges since entry.
    int m_mode, m_div, m_t;
    int m_base, m_tick;

    int    n_vec, n_err;
    bit    chk_en;
    bit    pin_on;
    string pin_name;
    int    pin_tick, pin_dclk, pin_busy, pin_cnt;

    function automatic int e_cnt();
        return (m_mode == 0) ? 0 : (m_t % m_div);
    endfunction

    function automatic int e_dclk();
        return (m_mode == 0) ? m_base : (m_base ^ ((m_t / m_div) & 1));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_div = DEF_DIV; m_t = 0; m_base = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        if (m_mode == 0) begin
            m_tick = 0;
            if (iCfgValid) m_div = (int'(iCfgDiv) < 2) ? 2 : int'(iCfgDiv);
            if (iStart) begin
                m_mode = 1; m_t = 0;
            end else if (iOneShot) begin
                m_mode = 2; m_t = 0;
            end
        end else if (iStop) begin
            m_mode = 0; m_t = 0; m_base = 0; m_tick = 0;
        end else begin
            m_t = m_t + 1;
            m_tick = (m_t % m_div == 0) ? 1 : 0;
            if (m_mode == 2 && m_t == m_div) begin
                m_mode = 0; m_base = m_base ^ 1; m_t = 0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of DUT against the model, plus literal pins.
    always @(negedge iClk) begin
        if (chk_en) begin
            check("tick", 32'(oTick), 32'(m_tick));
            check("divclk", 32'(oDivClk), 32'(e_dclk()));
            check("busy", 32'(oBusy), 32'(m_mode != 0));
            check("cfg_ready", 32'(oCfgReady), 32'(m_mode == 0));
            check("cnt", 32'(oCnt), 32'(e_cnt()));
            if (pin_on) begin
                check({pin_name, "_tick"}, 32'(oTick), 32'(pin_tick));
                check({pin_name, "_divclk"}, 32'(oDivClk), 32'(pin_dclk));
                check({pin_name, "_busy"}, 32'(oBusy), 32'(pin_busy));
                check({pin_name, "_cnt"}, 32'(oCnt), 32'(pin_cnt));
                check({pin_name, "_model_tick"}, 32'(m_tick), 32'(pin_tick));
                check({pin_name, "_model_cnt"}, 32'(e_cnt()), 32'(pin_cnt));
            end
        end
    end

    task automatic tick1();
        @(posedge iClk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic drive(input logic cv, input int cd, input logic st, input logic os, input logic sp);
        iCfgValid = cv; iCfgDiv = CNT_W'(cd); iStart = st; iOneShot = os; iStop = sp;
        tick1();
        iCfgValid = 1'b0; iCfgDiv = '0; iStart = 1'b0; iOneShot = 1'b0; iStop = 1'b0;
    endtask

    task automatic pin(input string nm, input int tk, input int dc, input int by, input int cn);
        pin_name = nm; pin_tick = tk; pin_dclk = dc; pin_busy = by; pin_cnt = cn;
        pin_on = 1'b1;
        @(negedge iClk);
        #1;
        pin_on = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; pin_on = 1'b0; pin_name = "";
        iRst = 1'b0; iCfgValid = 1'b0; iCfgDiv = '0;
        iStart = 1'b0; iOneShot = 1'b0; iStop = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #22 iRst = 1'b1;
        pin("reset", 0, 0, 0, 0);

        // Default divisor: first tick 4 edges after start.
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        run(4);
        pin("def_div", 1, 1, 1, 0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        pin("stop", 0, 0, 0, 0);

        // Load 5 and run two full periods.
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        run(5);
        pin("div5_a", 1, 1, 1, 0);
        run(5);
        pin("div5_b", 1, 0, 1, 0);
        run(3);
        pin("div5_cnt", 0, 0, 1, 3);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Clamp 0 -> 2 with config and start together; config ignored in RUN.
        drive(1'b1, 0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 9, 1'b0, 1'b0, 1'b0);
        run(7);
        pin("clamp", 1, 0, 1, 0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // One-shot with div 3.
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        run(3);
        pin("shot", 1, 1, 0, 0);
        tick1();
        pin("shot_after", 0, 1, 0, 0);
        run(5);

        // Stop coincident with the wrap cycle.
        drive(1'b1, 4, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        run(3);
        pin("pre_stop", 0, 1, 1, 3);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        pin("stop_wrap", 0, 0, 0, 0);

        // Start and one-shot together: free run wins.
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
        run(5);
        pin("st_os", 0, 1, 1, 1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-run, then default divisor again.
        drive(1'b1, 7, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        run(2);
        #2 iRst = 1'b0;
        model_reset();
        pin("async_rst", 0, 0, 0, 0);
        iRst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        run(4);
        pin("post_rst", 1, 1, 1, 0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        run(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
